// File: rtl/flick_conditioner_pkg.sv
// Shared types and default sizing for the flick conditioner and the bound flasher.
package flasher_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } flick_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 20;
  localparam int DEF_MIN_HIGH_CYCLES = 16;

endpackage

// File: rtl/flick_conditioner_if.sv
// Button-in / debounced-flick-out bundle between the conditioner and its user.
interface flick_conditioner_if;
  logic btn_raw;
  logic flick;
  logic flick_rise;
  logic flick_fall;
  logic busy;

  modport master (output btn_raw, input flick, flick_rise, flick_fall, busy);
  modport slave  (input btn_raw, output flick, flick_rise, flick_fall, busy);
endinterface

// File: rtl/flick_conditioner_sync.sv
// Plain flop-chain synchronizer, async active-high reset to 0.
module sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/flick_conditioner.sv
// Synchronize + debounce the raw flick button into a clean level with rise/fall pulses.
// Optional minimum-high stretch when FLICK_STRETCH_EN is defined.
module flick_conditioner
  import flasher_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_HIGH_CYCLES = DEF_MIN_HIGH_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  flick_conditioner_if.slave  fif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          btn_s;
  flick_state_t  state;
  logic [CW-1:0] cnt;
  logic          flick_q, rise_q, fall_q;

  sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (fif.btn_raw),
    .q   (btn_s)
  );

`ifdef FLICK_STRETCH_EN
  localparam int HW = $clog2(MIN_HIGH_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HIGH_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MIN_HIGH_CYCLES);
  logic [HW-1:0] hold;
  logic          stretch_rel;

  // Stretched high runs out, unless a new press is qualifying this very edge (merge).
  assign stretch_rel = flick_q && (hold >= HOLD_LAST) &&
                       ((state == IDLE_LOW) ||
                        ((state == WAIT_HIGH) && !(btn_s && cnt == CNT_LAST)));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE_LOW;
      cnt     <= '0;
      flick_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef FLICK_STRETCH_EN
      hold    <= '0;
`endif
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        IDLE_LOW: if (btn_s) begin state <= WAIT_HIGH; cnt <= CNT_ONE; end
        WAIT_HIGH: begin
          if (!btn_s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
            if (!flick_q) begin flick_q <= 1'b1; rise_q <= 1'b1; end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: if (!btn_s) begin state <= WAIT_LOW; cnt <= CNT_ONE; end
        WAIT_LOW: begin
          if (btn_s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
`ifdef FLICK_STRETCH_EN
            if (hold >= HOLD_LAST) begin flick_q <= 1'b0; fall_q <= 1'b1; end
`else
            flick_q <= 1'b0;
            fall_q  <= 1'b1;
`endif
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin state <= IDLE_LOW; cnt <= '0; end
      endcase
`ifdef FLICK_STRETCH_EN
      if (stretch_rel) begin flick_q <= 1'b0; fall_q <= 1'b1; end
      // hold reads 0 on the rise cycle and counts every cycle flick stays high
      if (!flick_q)             hold <= '0;
      else if (hold != HOLD_MAX) hold <= hold + HW'(1);
`endif
    end
  end

  assign fif.flick      = flick_q;
  assign fif.flick_rise = rise_q;
  assign fif.flick_fall = fall_q;
  assign fif.busy       = (state == WAIT_HIGH) || (state == WAIT_LOW);
endmodule

// File: tb/tb_flick_conditioner.sv
// Directed bench: default, DEBOUNCE=2 and DEBOUNCE=4/MIN_HIGH=16 instances side by side.
module tb_flick_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flick_conditioner_if i0 ();
  flick_conditioner_if i1 ();
  flick_conditioner_if i2 ();

  flick_conditioner u0 (.clk(clk), .rst(rst), .fif(i0));
  flick_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(2)) u1 (.clk(clk), .rst(rst), .fif(i1));
  flick_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .MIN_HIGH_CYCLES(16)) u2 (
    .clk(clk), .rst(rst), .fif(i2));

`ifdef FLICK_STRETCH_EN
  localparam int U2_FALL = 22;   // rise at 6 + 16 high cycles
`else
  localparam int U2_FALL = 12;   // rise at 6 + (4 + 2) high cycles
`endif

  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic o_flick, o_rise, o_fall, o_busy;

  always_comb begin
    o_flick = i0.flick; o_rise = i0.flick_rise; o_fall = i0.flick_fall; o_busy = i0.busy;
    case (sel)
      1: begin o_flick = i1.flick; o_rise = i1.flick_rise; o_fall = i1.flick_fall; o_busy = i1.busy; end
      2: begin o_flick = i2.flick; o_rise = i2.flick_rise; o_fall = i2.flick_fall; o_busy = i2.busy; end
      default: ;
    endcase
  end

  // kind 0: btn high on edges 1..len then low; kind 1: 3-cycle bounce for 30 edges then high
  typedef struct {
    string name;
    int    inst;
    int    kind;
    int    len;
    int    total;
    int    rise_e;   // 0 = no rise expected
    int    fall_e;   // 0 = no fall expected
    int    busy_e;   // edge after which busy must be 1
    int    fin_flick;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic v);
    i0.btn_raw = (sel == 0) && v;
    i1.btn_raw = (sel == 1) && v;
    i2.btn_raw = (sel == 2) && v;
  endtask

  task automatic do_reset();
    set_btn(1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int rises = 0, falls = 0, rise_e = 0, fall_e = 0, both = 0, busy_at = 0;
    logic b;
    sel = v.inst;
    do_reset();
    for (int e = 1; e <= v.total; e++) begin
      if (v.kind == 0) b = (e <= v.len);
      else             b = (e > 30) || (((e - 1) / 3) % 2 == 0);
      set_btn(b);
      @(posedge clk);
      #1;
      if (o_rise) begin rises++; rise_e = e; end
      if (o_fall) begin falls++; fall_e = e; end
      if (o_rise && o_fall) both++;
      if (e == v.busy_e) busy_at = int'(o_busy);
    end
    chk({v.name, " rise_count"}, rises, (v.rise_e != 0) ? 1 : 0);
    chk({v.name, " rise_edge"}, rise_e, v.rise_e);
    chk({v.name, " fall_count"}, falls, (v.fall_e != 0) ? 1 : 0);
    chk({v.name, " fall_edge"}, fall_e, v.fall_e);
    chk({v.name, " rise_fall_overlap"}, both, 0);
    chk({v.name, " busy_qual"}, busy_at, 1);
    chk({v.name, " final_flick"}, int'(o_flick), v.fin_flick);
    chk({v.name, " final_busy"}, int'(o_busy), 0);
  endtask

  initial begin
    int rises, rise_e;
    vecs[0] = '{"clean_press",   0, 0, 40, 90, 22, 62, 10, 0};
    vecs[1] = '{"glitch19",      0, 0, 19, 50,  0,  0, 10, 0};
    vecs[2] = '{"press20",       0, 0, 20, 70, 22, 42, 10, 0};
    vecs[3] = '{"bounce",        0, 1,  0, 80, 52,  0, 40, 1};
    vecs[4] = '{"db2_one_cycle", 1, 0,  1, 20,  0,  0,  3, 0};
    vecs[5] = '{"db2_two_cycle", 1, 0,  2, 20,  4,  6,  3, 0};
    vecs[6] = '{"db4_min_high",  2, 0,  6, 40,  6, U2_FALL, 4, 0};

    set_btn(1'b0);
    #2;
    chk("reset_flick",  int'(i0.flick | i1.flick | i2.flick), 0);
    chk("reset_rise",   int'(i0.flick_rise | i1.flick_rise | i2.flick_rise), 0);
    chk("reset_fall",   int'(i0.flick_fall | i1.flick_fall | i2.flick_fall), 0);
    chk("reset_busy",   int'(i0.busy | i1.busy | i2.busy), 0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // reset mid-qualification with the button held, then mid-high
    sel = 0;
    do_reset();
    set_btn(1'b1);
    repeat (12) @(posedge clk);
    #1 chk("midrst_busy_before", int'(o_busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy_now", int'(o_busy), 0);
    chk("midrst_flick_now", int'(o_flick), 0);
    chk("midrst_rise_now", int'(o_rise), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rises = 0; rise_e = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (o_rise) begin rises++; rise_e = e; end
    end
    chk("midrst_rise_count", rises, 1);
    chk("midrst_rise_edge", rise_e, 22);
    chk("midrst_flick_held", int'(o_flick), 1);
    #2 rst = 1'b1;
    #1 chk("highrst_flick_now", int'(o_flick), 0);
    set_btn(1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
